// File: rtl/instr_encoder.sv
// RV32I instruction encoder: accepts class/field requests over valid/ready, packs
// them into 32-bit instruction words and writes them sequentially to instruction memory.
module instr_encoder #(
  parameter int                ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              iClk,
  input  logic              iRstN,
  input  logic              iValid,
  output logic              oReady,
  input  logic [3:0]        iClass,
  input  logic [2:0]        iFunct3,
  input  logic [6:0]        iFunct7,
  input  logic [4:0]        iRd,
  input  logic [4:0]        iRs1,
  input  logic [4:0]        iRs2,
  input  logic [31:0]       iImm,
  input  logic              iLast,
  input  logic              iClear,
  output logic              oWrEn,
  output logic [ADDR_W-1:0] oWrAddr,
  output logic [31:0]       oWrData,
  output logic              oErr,
  output logic              oFull,
  output logic              oDone
);

  typedef enum logic [1:0] {IDLE, ENC, WR, DONE} state_t;

  localparam logic [3:0]    CLS_R      = 4'd0;
  localparam logic [3:0]    CLS_IALU   = 4'd1;
  localparam logic [3:0]    CLS_LOAD   = 4'd2;
  localparam logic [3:0]    CLS_STORE  = 4'd3;
  localparam logic [3:0]    CLS_BRANCH = 4'd4;
  localparam logic [3:0]    CLS_JAL    = 4'd5;
  localparam logic [3:0]    CLS_JALR   = 4'd6;
  localparam logic [3:0]    CLS_LUI    = 4'd7;
  localparam logic [3:0]    CLS_AUIPC  = 4'd8;
  localparam logic [ADDR_W:0] CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  state_t state, stateNext;

  logic [3:0]        cls_p0;
  logic [2:0]        funct3_p0;
  logic [6:0]        funct7_p0;
  logic [4:0]        rd_p0;
  logic [4:0]        rs1_p0;
  logic [4:0]        rs2_p0;
  logic signed [31:0] imm_p0;
  logic              last_p0;

  logic [31:0]       wrData_p1;
  logic              err_p1;
  logic [ADDR_W:0]   count;

  logic              accept;
  logic              legal;

  // Opcode map shared with the control decoder; unused fields are simply not referenced.
  function automatic logic [31:0] encode(
    input logic [3:0]         cls,
    input logic [2:0]         f3,
    input logic [6:0]         f7,
    input logic [4:0]         rd,
    input logic [4:0]         rs1,
    input logic [4:0]         rs2,
    input logic signed [31:0] imm
  );
    logic [31:0] word;
    word = '0;
    unique case (cls)
      CLS_R:      word = {f7, rs2, rs1, f3, rd, 7'h33};
      CLS_IALU:   word = {imm[11:0], rs1, f3, rd, 7'h13};
      CLS_LOAD:   word = {imm[11:0], rs1, f3, rd, 7'h03};
      CLS_JALR:   word = {imm[11:0], rs1, 3'b000, rd, 7'h67};
      CLS_STORE:  word = {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
      CLS_BRANCH: word = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
      CLS_LUI:    word = {imm[31:12], rd, 7'h37};
      CLS_AUIPC:  word = {imm[31:12], rd, 7'h17};
      CLS_JAL:    word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
      default:    word = '0;
    endcase
    return word;
  endfunction

  assign oFull   = count[ADDR_W];
  assign oReady  = (state == IDLE) && !oFull;
  assign accept  = iValid && oReady;
  assign legal   = (cls_p0 <= CLS_AUIPC);
  assign oWrEn   = (state == WR);
  assign oWrAddr = BASE_ADDR + count[ADDR_W-1:0];
  assign oWrData = wrData_p1;
  assign oErr    = err_p1;
  assign oDone   = (state == DONE);

  always_ff @(posedge iClk) begin
    if (!iRstN) state <= IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:    if (accept) stateNext = ENC;
      ENC:     stateNext = legal ? WR : IDLE;
      WR:      stateNext = last_p0 ? DONE : IDLE;
      DONE:    stateNext = DONE;
      default: stateNext = IDLE;
    endcase
    if (iClear) stateNext = IDLE;
  end

  // Stage p0: request fields captured on accept
  always_ff @(posedge iClk) begin
    if (accept) begin
      cls_p0    <= iClass;
      funct3_p0 <= iFunct3;
      funct7_p0 <= iFunct7;
      rd_p0     <= iRd;
      rs1_p0    <= iRs1;
      rs2_p0    <= iRs2;
      imm_p0    <= iImm;
      last_p0   <= iLast;
    end
  end

  // Stage p1: encoded word, error pulse and write counter
  always_ff @(posedge iClk) begin
    if (!iRstN) begin
      wrData_p1 <= '0;
      err_p1    <= 1'b0;
      count     <= '0;
    end else begin
      err_p1 <= (state == ENC) && !legal && !iClear;
      if (iClear)             count <= '0;
      else if (state == WR)   count <= count + CNT_ONE;
      if ((state == ENC) && legal && !iClear)
        wrData_p1 <= encode(cls_p0, funct3_p0, funct7_p0, rd_p0, rs1_p0, rs2_p0, imm_p0);
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: a default-size instance and a 4-word instance
// (BASE_ADDR=1) driven from the same stimulus.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        iRstN, iValid, iLast, iClear;
  logic [3:0]  iClass;
  logic [2:0]  iFunct3;
  logic [6:0]  iFunct7;
  logic [4:0]  iRd, iRs1, iRs2;
  logic [31:0] iImm;

  logic        oReady, oWrEn, oErr, oFull, oDone;
  logic [7:0]  oWrAddr;
  logic [31:0] oWrData;

  logic        sReady, sWrEn, sErr, sFull, sDone;
  logic [1:0]  sWrAddr;
  logic [31:0] sWrData;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(8), .BASE_ADDR(8'd0)) dut (
    .iClk(clk), .iRstN(iRstN), .iValid(iValid), .oReady(oReady),
    .iClass(iClass), .iFunct3(iFunct3), .iFunct7(iFunct7),
    .iRd(iRd), .iRs1(iRs1), .iRs2(iRs2), .iImm(iImm),
    .iLast(iLast), .iClear(iClear),
    .oWrEn(oWrEn), .oWrAddr(oWrAddr), .oWrData(oWrData),
    .oErr(oErr), .oFull(oFull), .oDone(oDone)
  );

  instr_encoder #(.ADDR_W(2), .BASE_ADDR(2'd1)) dutS (
    .iClk(clk), .iRstN(iRstN), .iValid(iValid), .oReady(sReady),
    .iClass(iClass), .iFunct3(iFunct3), .iFunct7(iFunct7),
    .iRd(iRd), .iRs1(iRs1), .iRs2(iRs2), .iImm(iImm),
    .iLast(iLast), .iClear(iClear),
    .oWrEn(sWrEn), .oWrAddr(sWrAddr), .oWrData(sWrData),
    .oErr(sErr), .oFull(sFull), .oDone(sDone)
  );

  typedef struct {
    logic [3:0]  cls;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        last;
    logic [31:0] data;
  } vec_t;

  vec_t vecs [12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic setFields(input vec_t v);
    iClass  = v.cls;
    iFunct3 = v.f3;
    iFunct7 = v.f7;
    iRd     = v.rd;
    iRs1    = v.rs1;
    iRs2    = v.rs2;
    iImm    = v.imm;
    iLast   = v.last;
  endtask

  // Returns in cycle T+3 with iValid still high, so successive calls are back-to-back.
  task automatic runVec(input vec_t v, input logic [7:0] expAddr);
    setFields(v);
    iValid = 1'b1;
    chk("readyIdle", 32'(oReady), 32'd1);
    tick();
    chk("readyEnc", 32'(oReady), 32'd0);
    chk("wrEnEnc", 32'(oWrEn), 32'd0);
    tick();
    chk("wrEn", 32'(oWrEn), 32'd1);
    chk("wrAddr", 32'(oWrAddr), 32'(expAddr));
    chk("wrData", oWrData, v.data);
    chk("readyWr", 32'(oReady), 32'd0);
    chk("errWr", 32'(oErr), 32'd0);
    tick();
  endtask

  initial begin
    vec_t v;
    logic [1:0] sAddr;

    //          cls    f3    f7      rd     rs1    rs2    imm            last  data
    vecs[0]  = '{4'd1, 3'd0, 7'h00,  5'd1,  5'd0,  5'd0,  32'd5,         1'b0, 32'h00500093};
    vecs[1]  = '{4'd0, 3'd0, 7'h00,  5'd3,  5'd1,  5'd2,  32'd0,         1'b0, 32'h002081B3};
    vecs[2]  = '{4'd3, 3'd2, 7'h00,  5'd0,  5'd1,  5'd2,  32'd8,         1'b0, 32'h0020A423};
    vecs[3]  = '{4'd4, 3'd0, 7'h00,  5'd0,  5'd1,  5'd2,  32'd8,         1'b0, 32'h00208463};
    vecs[4]  = '{4'd5, 3'd0, 7'h00,  5'd1,  5'd0,  5'd0,  32'd16,        1'b0, 32'h010000EF};
    vecs[5]  = '{4'd2, 3'd2, 7'h00,  5'd6,  5'd2,  5'd0,  32'hFFFFFFFC,  1'b0, 32'hFFC12303};
    vecs[6]  = '{4'd6, 3'd5, 7'h00,  5'd0,  5'd1,  5'd0,  32'd0,         1'b0, 32'h00008067};
    vecs[7]  = '{4'd8, 3'd0, 7'h00,  5'd10, 5'd0,  5'd0,  32'hFFFFF123,  1'b0, 32'hFFFFF517};
    vecs[8]  = '{4'd4, 3'd1, 7'h00,  5'd0,  5'd5,  5'd0,  32'hFFFFFFF8,  1'b0, 32'hFE029CE3};
    vecs[9]  = '{4'd5, 3'd0, 7'h00,  5'd0,  5'd0,  5'd0,  32'hFFFFFFFC,  1'b0, 32'hFFDFF06F};
    vecs[10] = '{4'd1, 3'd0, 7'h7F,  5'd2,  5'd2,  5'd31, 32'h000007FF,  1'b0, 32'h7FF10113};
    vecs[11] = '{4'd0, 3'd0, 7'h20,  5'd4,  5'd5,  5'd6,  32'hDEADBEEF,  1'b0, 32'h40628233};

    iRstN = 1'b0; iValid = 1'b0; iClear = 1'b0;
    setFields(vecs[0]);
    tick();
    tick();
    chk("rstReady", 32'(oReady), 32'd1);
    chk("rstWrEn", 32'(oWrEn), 32'd0);
    chk("rstAddr", 32'(oWrAddr), 32'd0);
    chk("rstData", oWrData, 32'd0);
    chk("rstErr", 32'(oErr), 32'd0);
    chk("rstFull", 32'(oFull), 32'd0);
    chk("rstDone", 32'(oDone), 32'd0);
    iRstN = 1'b1;

    runVec(vecs[0], 8'd0);
    iValid = 1'b0;
    iClear = 1'b1;
    tick();
    iClear = 1'b0;
    chk("clearAddr", 32'(oWrAddr), 32'd0);

    for (int i = 1; i < 12; i++) runVec(vecs[i], 8'(i - 1));

    // Illegal class: error pulse in T+2, no write, address unchanged
    iClass = 4'd12;
    iLast  = 1'b1;
    chk("illReady", 32'(oReady), 32'd1);
    tick();
    iValid = 1'b0;
    chk("illErrEnc", 32'(oErr), 32'd0);
    tick();
    chk("illErr", 32'(oErr), 32'd1);
    chk("illWrEn", 32'(oWrEn), 32'd0);
    tick();
    chk("illErrEnd", 32'(oErr), 32'd0);
    chk("illDone", 32'(oDone), 32'd0);

    v = '{4'd7, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h12345000, 1'b1, 32'h123452B7};
    runVec(v, 8'd11);
    chk("doneHigh", 32'(oDone), 32'd1);
    chk("doneReady", 32'(oReady), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("doneHoldWrEn", 32'(oWrEn), 32'd0);
      chk("doneHold", 32'(oDone), 32'd1);
    end
    iValid = 1'b0;
    iClear = 1'b1;
    tick();
    iClear = 1'b0;
    chk("clrDone", 32'(oDone), 32'd0);
    chk("clrReady", 32'(oReady), 32'd1);
    chk("clrAddr", 32'(oWrAddr), 32'd0);

    // Small instance: fill 4 words from BASE_ADDR=1 with wrap, then hold off
    iRstN = 1'b0;
    tick();
    iRstN = 1'b1;
    for (int k = 0; k < 4; k++) begin
      v = '{4'd1, 3'd0, 7'h00, 5'(k + 1), 5'd0, 5'd0, 32'(k), 1'b0,
            (32'(k) << 20) | (32'(k + 1) << 7) | 32'h13};
      setFields(v);
      iValid = 1'b1;
      sAddr = 2'(k + 1);
      tick();
      tick();
      chk("sWrEn", 32'(sWrEn), 32'd1);
      chk("sWrAddr", 32'(sWrAddr), 32'(sAddr));
      chk("sWrData", sWrData, v.data);
      tick();
    end
    chk("sFull", 32'(sFull), 32'd1);
    chk("sFullReady", 32'(sReady), 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("sHoldWrEn", 32'(sWrEn), 32'd0);
      chk("sHoldReady", 32'(sReady), 32'd0);
    end
    iValid = 1'b0;
    iClear = 1'b1;
    tick();
    iClear = 1'b0;
    chk("sClrReady", 32'(sReady), 32'd1);
    chk("sClrFull", 32'(sFull), 32'd0);
    chk("sClrAddr", 32'(sWrAddr), 32'd1);

    // Reset asserted during ENC drops the pending write
    tick();
    setFields(vecs[7]);
    iValid = 1'b1;
    tick();
    iValid = 1'b0;
    iRstN  = 1'b0;
    tick();
    chk("encRstWrEn", 32'(oWrEn), 32'd0);
    chk("encRstReady", 32'(oReady), 32'd1);
    chk("encRstAddr", 32'(oWrAddr), 32'd0);
    chk("encRstData", oWrData, 32'd0);
    chk("encRstErr", 32'(oErr), 32'd0);
    chk("encRstFull", 32'(oFull), 32'd0);
    chk("encRstDone", 32'(oDone), 32'd0);
    iRstN = 1'b1;
    tick();
    chk("encRstAfter", 32'(oWrEn), 32'd0);
    tick();
    chk("encRstAfter2", 32'(oWrEn), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
